// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle controller and instruction/data memory.
// The controller is the master: it raises requests and consumes acks.
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback, drives the
// datapath strobes, counts retired instructions and halts on ECALL, illegal opcode or ack timeout.
module multicycle_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               br_taken,
    multicycle_ctrl_if.master  mem,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               rf_we,
    output logic [1:0]         wb_sel,
    output logic               halted,
    output logic               illegal,
    output logic               timeout,
    output logic [2:0]         state,
    output logic [31:0]        retired
);

    localparam int unsigned      CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_LOAD    = 4'd1,
        CLS_STORE   = 4'd2,
        CLS_BRANCH  = 4'd3,
        CLS_UPPER   = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_SYS     = 4'd7,
        CLS_ILLEGAL = 4'd8
    } class_t;

    function automatic class_t decode_class(input logic [6:0] op);
        class_t c;
        case (op)
            7'b0110011, 7'b0010011: c = CLS_ALU;
            7'b0000011:             c = CLS_LOAD;
            7'b0100011:             c = CLS_STORE;
            7'b1100011:             c = CLS_BRANCH;
            7'b0110111, 7'b0010111: c = CLS_UPPER;
            7'b1101111:             c = CLS_JAL;
            7'b1100111:             c = CLS_JALR;
            7'b1110011:             c = CLS_SYS;
            default:                c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t            state_r, state_next;
    class_t            class_r, class_next;
    class_t            op_class_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next;
    logic [31:0]       retired_r;
    logic              halted_r, illegal_r, timeout_r;

    logic              imem_req_s, dmem_req_s, dmem_we_s, ir_we_s, pc_we_s, rf_we_s;
    logic [1:0]        pc_sel_s, wb_sel_s;
    logic              retire_s, set_illegal_s, set_timeout_s;

    assign op_class_s = decode_class(opcode);

    // Next-state, strobe decode and ack-wait counter update.
    always_comb begin
        state_next    = state_r;
        class_next    = class_r;
        cnt_next      = cnt_r;
        imem_req_s    = 1'b0;
        dmem_req_s    = 1'b0;
        dmem_we_s     = 1'b0;
        ir_we_s       = 1'b0;
        pc_we_s       = 1'b0;
        rf_we_s       = 1'b0;
        pc_sel_s      = 2'd0;
        wb_sel_s      = 2'd0;
        retire_s      = 1'b0;
        set_illegal_s = 1'b0;
        set_timeout_s = 1'b0;

        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (mem.imem_ack) begin
                    ir_we_s    = 1'b1;
                    state_next = S_DECODE;
                end else if (cnt_r == CNT_LIMIT) begin
                    set_timeout_s = 1'b1;
                    state_next    = S_HALT;
                end else begin
                    cnt_next = cnt_r + CNT_W'(1);
                end
            end
            S_DECODE: begin
                class_next = op_class_s;
                case (op_class_s)
                    CLS_SYS: begin
                        retire_s   = 1'b1;
                        state_next = S_HALT;
                    end
                    CLS_ILLEGAL: begin
                        set_illegal_s = 1'b1;
                        state_next    = S_HALT;
                    end
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (class_r)
                    CLS_ALU, CLS_UPPER, CLS_JAL, CLS_JALR: state_next = S_WB;
                    CLS_LOAD, CLS_STORE:                   state_next = S_MEM;
                    CLS_BRANCH: begin
                        pc_we_s    = 1'b1;
                        pc_sel_s   = br_taken ? 2'd1 : 2'd0;
                        retire_s   = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_HALT;
                endcase
            end
            S_MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (class_r == CLS_STORE);
                if (mem.dmem_ack) begin
                    if (class_r == CLS_STORE) begin
                        pc_we_s    = 1'b1;
                        retire_s   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (cnt_r == CNT_LIMIT) begin
                    set_timeout_s = 1'b1;
                    state_next    = S_HALT;
                end else begin
                    cnt_next = cnt_r + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_we_s    = 1'b1;
                pc_we_s    = 1'b1;
                retire_s   = 1'b1;
                state_next = S_FETCH;
                case (class_r)
                    CLS_LOAD:  wb_sel_s = 2'd1;
                    CLS_JAL:   begin wb_sel_s = 2'd2; pc_sel_s = 2'd1; end
                    CLS_JALR:  begin wb_sel_s = 2'd2; pc_sel_s = 2'd2; end
                    default:   begin wb_sel_s = 2'd0; pc_sel_s = 2'd0; end
                endcase
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_HALT;
        endcase

        // Any state change means a fresh wait window for the next FETCH/MEM.
        if (state_next != state_r) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_next;
        end
    end

    // State, class, wait counter, retire count and sticky halt flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_FETCH;
            class_r   <= CLS_ILLEGAL;
            cnt_r     <= '0;
            retired_r <= 32'd0;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next;
            class_r   <= class_next;
            cnt_r     <= cnt_next;
            retired_r <= retired_r + {31'd0, retire_s};
            halted_r  <= halted_r | (state_next == S_HALT);
            illegal_r <= illegal_r | set_illegal_s;
            timeout_r <= timeout_r | set_timeout_s;
        end
    end

    // Reset overrides state decode so no strobe leaks while reset is held.
    assign mem.imem_req = imem_req_s & ~reset;
    assign mem.dmem_req = dmem_req_s & ~reset;
    assign mem.dmem_we  = dmem_we_s  & ~reset;
    assign ir_we        = ir_we_s    & ~reset;
    assign pc_we        = pc_we_s    & ~reset;
    assign rf_we        = rf_we_s    & ~reset;
    assign pc_sel       = pc_we ? pc_sel_s : 2'd0;
    assign wb_sel       = rf_we ? wb_sel_s : 2'd0;

    assign halted  = halted_r;
    assign illegal = illegal_r;
    assign timeout = timeout_r;
    assign state   = state_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl plus directed halt/timeout/reset scenarios.
module tb_multicycle_ctrl;

    localparam int unsigned TO      = 4;
    localparam int          N_INSTR = 150;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [6:0]  opcode   = 7'd0;
    logic        br_taken = 1'b0;
    logic        ir_we, pc_we, rf_we, halted, illegal, timeout;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .br_taken (br_taken),
        .mem      (mif),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .halted   (halted),
        .illegal  (illegal),
        .timeout  (timeout),
        .state    (state),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        int          ireq;
        int          dreq;
        logic        dwe;
        logic        rf_we;
        logic [1:0]  pc_sel;
        logic [1:0]  wb_sel;
        logic [31:0] ret;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Class index: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 UPPER, 5 JAL, 6 JALR
    function automatic logic [6:0] op_for(input int k, input bit alt);
        case (k)
            0:       return alt ? 7'b0010011 : 7'b0110011;
            1:       return 7'b0000011;
            2:       return 7'b0100011;
            3:       return 7'b1100011;
            4:       return alt ? 7'b0010111 : 7'b0110111;
            5:       return 7'b1101111;
            default: return 7'b1100111;
        endcase
    endfunction

    // Instruction-level reference: cycle cost, handshake counts and commit selects.
    function automatic exp_t model(input int k, input bit bt, input int di, input int dd, input int idx);
        exp_t e;
        e.ireq   = di + 1;
        e.dreq   = (k == 1 || k == 2) ? dd + 1 : 0;
        e.dwe    = (k == 2);
        e.rf_we  = !(k == 2 || k == 3);
        e.wb_sel = (k == 1) ? 2'd1 : ((k == 5 || k == 6) ? 2'd2 : 2'd0);
        e.pc_sel = (k == 3) ? {1'b0, bt} : ((k == 5) ? 2'd1 : ((k == 6) ? 2'd2 : 2'd0));
        case (k)
            1:       e.cycles = 5 + di + dd;
            2:       e.cycles = 4 + di + dd;
            3:       e.cycles = 3 + di;
            default: e.cycles = 4 + di;
        endcase
        e.ret = 32'(idx);
        return e;
    endfunction

    // Monitor: accumulates per-instruction activity, compares at each commit cycle.
    int   m_cyc = 0, m_ireq = 0, m_dreq = 0, m_irwe = 0, m_leak = 0;
    logic m_dwe = 1'b0;
    exp_t m_e;

    always @(negedge clk) begin
        #2;
        if (!mon_en) begin
            m_cyc = 0; m_ireq = 0; m_dreq = 0; m_irwe = 0; m_leak = 0; m_dwe = 1'b0;
        end else begin
            m_cyc++;
            m_ireq += int'(mif.imem_req);
            m_dreq += int'(mif.dmem_req);
            m_irwe += int'(ir_we);
            m_dwe  |= mif.dmem_we;
            if (!pc_we && pc_sel != 2'd0) m_leak++;
            if (!rf_we && wb_sel != 2'd0) m_leak++;
            if (pc_we || rf_we) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_commit", 32'd1, 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    check("cycles",   32'(m_cyc),  32'(m_e.cycles));
                    check("imem_req", 32'(m_ireq), 32'(m_e.ireq));
                    check("dmem_req", 32'(m_dreq), 32'(m_e.dreq));
                    check("ir_we",    32'(m_irwe), 32'd1);
                    check("dmem_we",  32'(m_dwe),  32'(m_e.dwe));
                    check("rf_we",    32'(rf_we),  32'(m_e.rf_we));
                    check("pc_we",    32'(pc_we),  32'd1);
                    check("pc_sel",   32'(pc_sel), 32'(m_e.pc_sel));
                    check("wb_sel",   32'(wb_sel), 32'(m_e.wb_sel));
                    check("retired",  retired,     m_e.ret);
                    check("sel_leak", 32'(m_leak), 32'd0);
                end
                m_cyc = 0; m_ireq = 0; m_dreq = 0; m_irwe = 0; m_leak = 0; m_dwe = 1'b0;
            end
        end
    end

    // Drive one instruction; stray acks are injected where the DUT must ignore them.
    task automatic run_instr(input int k, input bit bt, input int di, input int dd, input int idx);
        sb.push_back(model(k, bt, di, dd, idx));
        opcode   = op_for(k, 1'($urandom));
        br_taken = bt;
        for (int w = 0; w < di; w++) begin
            mif.imem_ack = 1'b0; mif.dmem_ack = 1'($urandom); @(negedge clk);
        end
        mif.imem_ack = 1'b1; mif.dmem_ack = 1'($urandom); @(negedge clk);
        mif.imem_ack = 1'($urandom); mif.dmem_ack = 1'($urandom); @(negedge clk);
        opcode = 7'($urandom);
        mif.imem_ack = 1'($urandom); mif.dmem_ack = 1'($urandom); @(negedge clk);
        if (k == 1 || k == 2) begin
            for (int w = 0; w < dd; w++) begin
                mif.dmem_ack = 1'b0; mif.imem_ack = 1'($urandom); @(negedge clk);
            end
            mif.dmem_ack = 1'b1; mif.imem_ack = 1'($urandom); @(negedge clk);
            if (k == 1) begin
                mif.imem_ack = 1'($urandom); mif.dmem_ack = 1'($urandom); @(negedge clk);
            end
        end else if (k != 3) begin
            mif.imem_ack = 1'($urandom); mif.dmem_ack = 1'($urandom); @(negedge clk);
        end
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
    endtask

    task automatic cyc(input logic ia, input logic da);
        mif.imem_ack = ia;
        mif.dmem_ack = da;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stray;
        mif.imem_ack = 1'b0;
        mif.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state",   32'(state),   32'd0);
        check("rst_retired", retired,      32'd0);
        check("rst_flags",   32'({halted, illegal, timeout}), 32'd0);
        check("rst_imem_req", 32'(mif.imem_req), 32'd0);
        mif.imem_ack = 1'b1;
        #1;
        check("rst_ir_we", 32'(ir_we), 32'd0);
        mif.imem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("first_imem_req", 32'(mif.imem_req), 32'd1);

        mon_en = 1'b1;
        for (int i = 0; i < N_INSTR; i++) begin
            run_instr($urandom_range(0, 6), 1'($urandom), $urandom_range(0, TO),
                      $urandom_range(0, TO), i);
        end
        mon_en = 1'b0;
        #1;
        check("sb_left",        32'(sb.size()), 32'd0);
        check("retired_total",  retired,        32'(N_INSTR));

        // Illegal opcode halts without retiring and stays silent.
        opcode = 7'b0000000;
        cyc(1'b1, 1'b0); #1;
        check("ill_decode_state", 32'(state), 32'd1);
        cyc(1'b0, 1'b0); #1;
        check("ill_state",   32'(state), 32'd5);
        check("ill_flags",   32'({halted, illegal, timeout}), 32'b110);
        check("ill_retired", retired, 32'(N_INSTR));
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'($urandom), 1'($urandom)); #1;
            stray += int'(mif.imem_req | mif.dmem_req | ir_we | pc_we | rf_we);
        end
        check("halt_strobes", 32'(stray), 32'd0);
        check("halt_stays",   32'(state), 32'd5);

        // Asynchronous reset out of HALT, then ECALL.
        reset = 1'b1; #1;
        check("rst2_state",   32'(state), 32'd0);
        check("rst2_retired", retired,    32'd0);
        check("rst2_flags",   32'({halted, illegal, timeout}), 32'd0);
        @(negedge clk); reset = 1'b0; #1;
        check("rst2_imem_req", 32'(mif.imem_req), 32'd1);
        opcode = 7'b1110011;
        cyc(1'b1, 1'b0); #1;
        check("ecall_decode", 32'(state), 32'd1);
        cyc(1'b0, 1'b0); #1;
        check("ecall_state",   32'(state), 32'd5);
        check("ecall_flags",   32'({halted, illegal, timeout}), 32'b100);
        check("ecall_retired", retired, 32'd1);

        // Fetch timeout with no ack.
        reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0;
        repeat (4) cyc(1'b0, 1'b0);
        #1;
        check("to_not_yet_state", 32'(state), 32'd0);
        check("to_not_yet_flag",  32'(timeout), 32'd0);
        cyc(1'b0, 1'b0); #1;
        check("to_state", 32'(state), 32'd5);
        check("to_flags", 32'({halted, illegal, timeout}), 32'b101);

        // Ack on the last allowed cycle wins.
        reset = 1'b1; #1;
        @(negedge clk); reset = 1'b0;
        opcode = 7'b0110011;
        repeat (4) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0); #1;
        check("late_ack_state", 32'(state),   32'd1);
        check("late_ack_flag",  32'(timeout), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0); #1;
        check("late_ack_wb", 32'({state, rf_we, pc_we}), 32'({3'd4, 1'b1, 1'b1}));
        cyc(1'b0, 1'b0); #1;
        check("late_ack_retired", retired, 32'd1);

        // Reset during a MEM wait aborts the load.
        opcode = 7'b0000011;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0); #1;
        check("mem_state", 32'(state), 32'd3);
        check("mem_req",   32'({mif.dmem_req, mif.dmem_we}), 32'b10);
        cyc(1'b0, 1'b0); #1;
        reset = 1'b1; #1;
        check("abort_dmem_req", 32'(mif.dmem_req), 32'd0);
        check("abort_state",    32'(state),        32'd0);
        check("abort_retired",  retired,           32'd0);
        check("abort_strobes",  32'({pc_we, rf_we, halted, illegal, timeout}), 32'd0);
        @(negedge clk); reset = 1'b0; #1;
        check("resume_imem_req", 32'(mif.imem_req), 32'd1);
        opcode = 7'b0110011;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0); #1;
        check("resume_wb", 32'({rf_we, wb_sel, pc_sel}), 32'b10000);
        cyc(1'b0, 1'b0); #1;
        check("resume_retired", retired, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I soft processor. It sequences fetch, decode, execute, memory and writeback around the instruction decoder, register file, ALU and PC. It handles the req/ack handshakes to instruction and data memory, selects the next PC, counts retired instructions, and halts on ECALL, illegal opcode or memory timeout. It consumes the decoder's `opcode` and the ALU's branch-compare result, and drives every datapath enable.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles a memory request may wait for ack before timeout halt; must be ≥1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `opcode` in 7: decoder opcode field, valid from DECODE onward.
- `br_taken` in 1: branch comparator result, valid in EXEC.
- `imem_ack` in 1: instruction memory ack; instruction data valid this cycle.
- `dmem_ack` in 1: data memory ack.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a store.
- `ir_we` out 1: latch instruction register.
- `pc_we` out 1: update PC.
- `pc_sel` out 2: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR).
- `rf_we` out 1: register file write.
- `wb_sel` out 2: 0 = ALU, 1 = load data, 2 = PC+4.
- `halted` out 1: sticky halt.
- `illegal` out 1: sticky; halt caused by unsupported opcode.
- `timeout` out 1: sticky; halt caused by missing ack.
- `state` out 3: current state, for debug.
- `retired` out 32: retired-instruction count.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Values 6 and 7 are unreachable; if entered, go to HALT.
- Instruction classes are latched into a class register in DECODE:
  - ALU: 0110011, 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - UPPER: 0110111, 0010111
  - JAL: 1101111
  - JALR: 1100111
  - SYS: 1110011
  - Any other opcode is ILLEGAL.
- FETCH: `imem_req`=1. On `imem_ack`, pulse `ir_we` in the same cycle and go to DECODE.
- DECODE:
  - SYS: `retired`+1, go to HALT.
  - ILLEGAL: set `illegal`, go to HALT; no retire.
  - Otherwise go to EXEC.
- EXEC:
  - ALU, UPPER, JAL, JALR: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: `pc_we`=1, `pc_sel`=`br_taken`?1:0, `retired`+1, go to FETCH.
- MEM: `dmem_req`=1, `dmem_we`=(class==STORE). On `dmem_ack`:
  - STORE: `pc_we`=1, `pc_sel`=0, `retired`+1, go to FETCH.
  - LOAD: go to WB.
- WB:
  - `rf_we`=1 and `pc_we`=1, `retired`+1, go to FETCH.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, else 0.
  - `pc_sel`: 1 for JAL, 2 for JALR, else 0.
  - Writes to x0 are suppressed by the register file, not here.
- HALT: all strobes 0, `halted`=1, no exit except reset.
- Timeout counter:
  - Cleared on every entry to FETCH or MEM; increments each cycle the state waits without ack.
  - When it reaches `ACK_TIMEOUT` with ack still low, set `timeout` and go to HALT.
  - Ack arriving on the cycle the count equals `ACK_TIMEOUT` wins: normal transition, no timeout.
- Acks in states not requesting them are ignored. `opcode` is sampled only in DECODE.
- `retired` wraps 0xFFFFFFFF→0.
- All strobes (`imem_req`, `dmem_req`, `dmem_we`, `ir_we`, `pc_we`, `rf_we`) are decoded from state, class and ack. `pc_sel` and `wb_sel` are 0 whenever `pc_we` or `rf_we` respectively is 0.

## Timing
- Reset asserted: state=FETCH, `retired`=0, `halted`=`illegal`=`timeout`=0, timeout counter=0. All strobes are forced 0 while `reset` is high, overriding state decode.
- First `imem_req` appears on the first cycle after `reset` deasserts.
- Zero-wait memory (ack in the same cycle as req) gives these cycles per instruction:
  - ALU, UPPER, JAL, JALR: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH: 3
  - SYS/ILLEGAL: 2 cycles to HALT.
- Each ack wait cycle adds 1.
- `retired` increments on the clock edge ending the retiring cycle.
- Reset mid-instruction, including mid-MEM: aborts immediately and asynchronously; no partial `rf_we`/`pc_we` is seen after the reset edge.

## Test plan
- **Reset then ADD** (opcode 0110011), zero-wait acks: states 0,1,2,4; `ir_we` in cycle 0; `rf_we`=1, `pc_we`=1, `wb_sel`=0, `pc_sel`=0 in cycle 3; `retired`=1 after 4 cycles.
- **LW with `dmem_ack` delayed 3 cycles**: MEM held 4 cycles with `dmem_req`=1, `dmem_we`=0; then WB with `wb_sel`=1; total 8 cycles; SW variant retires from MEM with `dmem_we`=1, no `rf_we`.
- **Branches**: BEQ with `br_taken`=1 gives `pc_sel`=1 in EXEC and 3-cycle retire; `br_taken`=0 gives `pc_sel`=0. JAL in WB gives `pc_sel`=1, `wb_sel`=2; JALR gives `pc_sel`=2, `wb_sel`=2.
- **Halt sources**: opcode 0000000 sets `illegal`=1, `halted`=1, `retired` unchanged, no further `imem_req` for 20 cycles. ECALL halts with `retired`+1 and `illegal`=0.
- **Timeout** with `ACK_TIMEOUT`=4 and `imem_ack` held low: `timeout`=1 and state=5 after 5 FETCH cycles. Ack on exactly the 5th FETCH cycle gives a normal DECODE with no timeout.
- **Reset mid-MEM**: assert `reset` during a MEM wait; `dmem_req` drops immediately, state=0, `retired`=0, flags cleared; normal fetch resumes after deassert.
